// File: rtl/req_encoder_8to3.sv
// rtl/req_encoder_8to3.sv - event pulse collector emitting binary line indices over valid/ready
module req_encoder_8to3 #(
    parameter int N           = 8,
    parameter int IDX_W       = 3,
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic             busy,
    output logic             overrun
);

    logic [N-1:0]     pending_q, pending_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic             overrun_q, overrun_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [IDX_W-1:0] sel_idx;
    logic             load;
    logic [N-1:0]     load_mask;

    // Pick the next pending line from the registered mask only, never from same-cycle req_in.
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        sel_idx = '0;
        found   = 1'b0;
        cand    = '0;
        if (ROUND_ROBIN) begin
            // Index arithmetic wraps naturally because N is a power of two; k == N lands on rr_ptr itself.
            for (int k = 1; k <= N; k++) begin
                cand = rr_ptr_q + IDX_W'(k);
                if (!found && pending_q[cand]) begin
                    sel_idx = cand;
                    found   = 1'b1;
                end
            end
        end else begin
            // Scan downward so the lowest set bit is the last to win.
            for (int i = N - 1; i >= 0; i--) begin
                if (pending_q[i]) begin
                    sel_idx = IDX_W'(i);
                end
            end
        end
    end

    // Load/capture/overrun next-state logic.
    always_comb begin
        load        = (!out_valid_q || out_ready) && (|pending_q);
        load_mask   = load ? (N'(1) << sel_idx) : '0;
        pending_d   = (pending_q & ~load_mask) | req_in;
        overrun_d   = overrun_q | (|(req_in & pending_q & ~load_mask));
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_idx_d   = sel_idx;
            rr_ptr_d    = sel_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset discards pending and held events and ignores req_in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            overrun_q   <= 1'b0;
            rr_ptr_q    <= IDX_W'(N - 1);
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            overrun_q   <= overrun_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign overrun   = overrun_q;
    assign busy      = (|pending_q) | out_valid_q;

endmodule

// File: tb/tb_req_encoder_8to3.sv
// tb/tb_req_encoder_8to3.sv - scoreboard bench for req_encoder_8to3 in both priority modes
module tb_req_encoder_8to3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       out_ready;
    logic [7:0] req_a, req_b;
    logic       valid_a, valid_b, busy_a, busy_b, ovr_a, ovr_b;
    logic [2:0] idx_a, idx_b;

    int errors = 0;
    int checks = 0;
    logic [2:0] exp_a[$];
    logic [2:0] exp_b[$];

    always #5 clk = ~clk;

    req_encoder_8to3 #(.N(8), .IDX_W(3), .ROUND_ROBIN(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_in(req_a), .out_ready(out_ready),
        .out_valid(valid_a), .out_idx(idx_a), .busy(busy_a), .overrun(ovr_a)
    );

    req_encoder_8to3 #(.N(8), .IDX_W(3), .ROUND_ROBIN(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_in(req_b), .out_ready(out_ready),
        .out_valid(valid_b), .out_idx(idx_b), .busy(busy_b), .overrun(ovr_b)
    );

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0 || busy_a || busy_b) && n < 60) begin
            tick();
            n++;
        end
        chk({name, "_drain_in_time"}, (n < 60) ? 1 : 0, 1);
        chk({name, "_queue_a_empty"}, exp_a.size(), 0);
        chk({name, "_busy_a_low"}, int'(busy_a), 0);
    endtask

    // Monitors pop the expected index on every accepted transfer.
    always @(negedge clk) begin
        if (rst_n && valid_a && out_ready) begin
            if (exp_a.size() == 0) chk("a_unexpected_transfer", int'(idx_a), -1);
            else chk("a_idx", int'(idx_a), int'(exp_a.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (rst_n && valid_b && out_ready) begin
            if (exp_b.size() == 0) chk("b_unexpected_transfer", int'(idx_b), -1);
            else chk("b_idx", int'(idx_b), int'(exp_b.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset with all lines active
        rst_n = 1'b0; req_a = 8'hFF; req_b = 8'hFF; out_ready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1; req_a = 8'h00; req_b = 8'h00;
        tick();
        chk("rst_valid_a", int'(valid_a), 0);
        chk("rst_busy_a", int'(busy_a), 0);
        chk("rst_ovr_a", int'(ovr_a), 0);
        chk("rst_idx_a", int'(idx_a), 0);
        chk("rst_valid_b", int'(valid_b), 0);
        chk("rst_busy_b", int'(busy_b), 0);

        // 2: single pulse, latency of two edges
        exp_a.push_back(3'd3);
        req_a = 8'h08;
        tick();
        req_a = 8'h00;
        chk("lat_valid_after_1_edge", int'(valid_a), 0);
        tick();
        chk("lat_valid_after_2_edges", int'(valid_a), 1);
        chk("lat_idx", int'(idx_a), 3);
        tick();
        chk("single_valid_drops", int'(valid_a), 0);
        drain("t2");

        // 3: lowest-first ordering
        exp_a.push_back(3'd0); exp_a.push_back(3'd2);
        exp_a.push_back(3'd5); exp_a.push_back(3'd7);
        req_a = 8'hA5;
        tick();
        req_a = 8'h00;
        drain("t3");
        chk("t3_no_overrun", int'(ovr_a), 0);

        // 4: backpressure holds output stable
        out_ready = 1'b0;
        req_a = 8'h81;
        tick();
        req_a = 8'h00;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid_held", int'(valid_a), 1);
            chk("bp_idx_held", int'(idx_a), 0);
            tick();
        end
        exp_a.push_back(3'd0); exp_a.push_back(3'd7);
        out_ready = 1'b1;
        drain("t4");

        // 5: overrun while an earlier event is held
        out_ready = 1'b0;
        req_a = 8'h01; tick(); req_a = 8'h00; tick(); tick();
        req_a = 8'h10; tick(); req_a = 8'h00; tick();
        chk("ovr_not_yet", int'(ovr_a), 0);
        req_a = 8'h10; tick(); req_a = 8'h00; tick();
        chk("ovr_set", int'(ovr_a), 1);
        exp_a.push_back(3'd0); exp_a.push_back(3'd4);
        out_ready = 1'b1;
        drain("t5");
        chk("ovr_sticky", int'(ovr_a), 1);

        // 6: held request, fixed versus rotating priority (held 6 cycles)
        for (int i = 0; i < 6; i++) exp_a.push_back(3'd1);
        exp_a.push_back(3'd6);
        for (int i = 0; i < 7; i++) exp_b.push_back((i % 2 == 0) ? 3'd1 : 3'd6);
        req_a = 8'h42; req_b = 8'h42;
        repeat (6) tick();
        req_a = 8'h00; req_b = 8'h00;
        drain("t6");
        chk("t6_queue_b_empty", exp_b.size(), 0);
        chk("t6_busy_b_low", int'(busy_b), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
